// File: rtl/sudoku_pkg.sv
// Purpose: shared geometry, FSM encoding, request record and error codes for digit entry.
// Latency: none (types, constants and a pure address function).
// Backpressure: not applicable.
package sudoku_pkg;

    localparam int BLKSIZE = 52;
    localparam int TRACK_W = BLKSIZE * BLKSIZE;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CELL     = 2'd1;
    localparam logic [1:0] ERR_REJECT   = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLS   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERASE = 3'd4
    } state_e;

    typedef enum logic {
        REQ_DRAW  = 1'b0,
        REQ_ERASE = 1'b1
    } req_kind_e;

    typedef struct packed {
        req_kind_e  kind;
        logic [3:0] bx;
        logic [3:0] by;
    } req_t;

    // Linear board address y*9+x; only meaningful for coordinates 0..8 (max 80).
    function automatic logic [6:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
        return ({3'b000, y} * 7'd9) + {3'b000, x};
    endfunction

endpackage

// File: rtl/entry_pending_buf.sv
// Purpose: one-deep holding register for a request that arrived while the sequencer was busy.
// Latency: contents visible the cycle after load; pop empties it on the same edge.
// Backpressure: none inside; caller must not load when full unless it pops the same cycle.
module entry_pending_buf
    import sudoku_pkg::*;
#(
    parameter int TRACK_W = sudoku_pkg::TRACK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  req_t               i_load_req,
    input  logic [TRACK_W-1:0] i_load_track,
    input  logic               i_pop,
    output logic               o_full,
    output req_t               o_req,
    output logic [TRACK_W-1:0] o_track
);

    logic               r_full;
    req_t               r_req;
    logic [TRACK_W-1:0] r_track;

    // Load takes priority over pop so a pop-and-refill in one cycle keeps the slot occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_req   <= '0;
            r_track <= '0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_req   <= i_load_req;
            r_track <= i_load_track;
        end else if (i_pop) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_req   = r_req;
    assign o_track = r_track;

endmodule

// File: rtl/sudoku_entry_ctrl.sv
// Purpose: sequences draw -> classify -> board write, plus cell erase, sharing one write port.
// Latency: erase writes 1 cycle after acceptance; draw raises cls_start 1 cycle after acceptance.
// Backpressure: one pending slot absorbs a request while busy; further requests drop with err 3.
module sudoku_entry_ctrl #(
    parameter int BLKSIZE = sudoku_pkg::BLKSIZE,
    parameter int TRACK_W = BLKSIZE * BLKSIZE,
    parameter int TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_draw_valid,
    input  logic [TRACK_W-1:0] i_draw_track,
    input  logic [3:0]         i_draw_bx,
    input  logic [3:0]         i_draw_by,
    input  logic               i_erase_req,
    input  logic [3:0]         i_erase_bx,
    input  logic [3:0]         i_erase_by,
    input  logic [80:0]        i_given_mask,
    output logic               o_cls_start,
    output logic [TRACK_W-1:0] o_cls_track,
    input  logic               i_cls_done,
    input  logic [3:0]         i_cls_digit,
    output logic               o_wr_en,
    output logic [6:0]         o_wr_addr,
    output logic [3:0]         o_wr_data,
    output logic               o_busy,
    output logic               o_err,
    output logic [1:0]         o_err_code
);
    import sudoku_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TRACK_W-1:0] r_track;
    logic [6:0]         r_addr;
    logic               r_cls_start;
    logic               r_wr_en;
    logic [6:0]         r_wr_addr;
    logic [3:0]         r_wr_data;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic               w_idle;
    logic               w_slot_full;
    req_t               w_slot_req;
    logic [TRACK_W-1:0] w_slot_track;
    logic               w_sel_vld;
    req_t               w_sel_req;
    logic [TRACK_W-1:0] w_sel_track;
    logic [6:0]         w_sel_addr;
    logic [127:0]       w_mask_ext;
    logic               w_sel_ok;
    logic               w_direct;
    logic               w_erase_cand;
    logic               w_draw_cand;
    logic               w_space;
    logic               w_load_erase;
    logic               w_load_draw;
    logic               w_load;
    req_t               w_load_req;
    logic               w_overflow;
    logic               w_pop;
    logic               w_digit_ok;

    assign w_idle = (r_state == ST_IDLE);

    // Pick the request IDLE serves this cycle: pending slot, then erase, then draw.
    always_comb begin
        w_sel_vld   = 1'b0;
        w_sel_req   = '0;
        w_sel_track = i_draw_track;
        if (w_idle) begin
            if (w_slot_full) begin
                w_sel_vld   = 1'b1;
                w_sel_req   = w_slot_req;
                w_sel_track = w_slot_track;
            end else if (i_erase_req) begin
                w_sel_vld = 1'b1;
                w_sel_req = '{REQ_ERASE, i_erase_bx, i_erase_by};
            end else if (i_draw_valid) begin
                w_sel_vld = 1'b1;
                w_sel_req = '{REQ_DRAW, i_draw_bx, i_draw_by};
            end
        end
    end

    // Cell check: coordinates 0..8 and not a puzzle given. Mask padded so any address indexes safely.
    assign w_sel_addr = cell_addr(w_sel_req.bx, w_sel_req.by);
    assign w_mask_ext = {47'b0, i_given_mask};
    assign w_sel_ok   = (w_sel_req.bx < 4'd9) && (w_sel_req.by < 4'd9) && !w_mask_ext[w_sel_addr];

    // New arrivals not served directly compete for the slot; erase wins it over a simultaneous draw.
    // In IDLE with a full slot the slot is popped this cycle, so it has room for one arrival.
    assign w_direct     = w_idle && !w_slot_full;
    assign w_erase_cand = i_erase_req && !w_direct;
    assign w_draw_cand  = i_draw_valid && !(w_direct && !i_erase_req);
    assign w_space      = w_idle || !w_slot_full;
    assign w_load_erase = w_erase_cand && w_space;
    assign w_load_draw  = w_draw_cand && !w_erase_cand && w_space;
    assign w_load       = w_load_erase || w_load_draw;
    assign w_load_req   = w_load_erase ? '{REQ_ERASE, i_erase_bx, i_erase_by}
                                       : '{REQ_DRAW, i_draw_bx, i_draw_by};
    assign w_overflow   = (w_erase_cand && !w_space) || (w_draw_cand && (w_erase_cand || !w_space));
    assign w_pop        = w_idle && w_slot_full;

    assign w_digit_ok = (i_cls_digit != 4'd0) && (i_cls_digit <= 4'd9);

    entry_pending_buf #(
        .TRACK_W (TRACK_W)
    ) u_pending (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_load_req   (w_load_req),
        .i_load_track (i_draw_track),
        .i_pop        (w_pop),
        .o_full       (w_slot_full),
        .o_req        (w_slot_req),
        .o_track      (w_slot_track)
    );

    // Main sequencer with registered strobes. If an FSM error coincides with an overflow drop,
    // the FSM's own code is reported since it is assigned later in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_track     <= '0;
            r_addr      <= '0;
            r_cls_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_cls_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            if (w_overflow) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_OVERFLOW;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_vld) begin
                        if (!w_sel_ok) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_CELL;
                        end else if (w_sel_req.kind == REQ_DRAW) begin
                            r_track     <= w_sel_track;
                            r_addr      <= w_sel_addr;
                            r_cls_start <= 1'b1;
                            r_state     <= ST_CLS;
                        end else begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_sel_addr;
                            r_wr_data <= 4'd0;
                            r_state   <= ST_ERASE;
                        end
                    end
                end
                ST_CLS: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_cls_done) begin
                        r_state <= ST_WRITE;
                        if (w_digit_ok) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= i_cls_digit;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_REJECT;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_REJECT;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                ST_ERASE: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cls_start = r_cls_start;
    assign o_cls_track = r_track;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_busy      = !w_idle || w_slot_full;

endmodule

// File: tb/tb_sudoku_entry_ctrl.sv
// Purpose: directed checks of draw/erase sequencing, cell checks, timeout, pending slot and reset.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_sudoku_entry_ctrl;

    localparam int TW = 2704;

    logic          clk;
    logic          rst;
    logic          draw_valid;
    logic [TW-1:0] draw_track;
    logic [3:0]    draw_bx;
    logic [3:0]    draw_by;
    logic          erase_req;
    logic [3:0]    erase_bx;
    logic [3:0]    erase_by;
    logic [80:0]   given_mask;
    logic          cls_start;
    logic [TW-1:0] cls_track;
    logic          cls_done;
    logic [3:0]    cls_digit;
    logic          wr_en;
    logic [6:0]    wr_addr;
    logic [3:0]    wr_data;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;

    sudoku_entry_ctrl #(
        .BLKSIZE (52),
        .TRACK_W (TW),
        .TIMEOUT (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_draw_valid (draw_valid),
        .i_draw_track (draw_track),
        .i_draw_bx    (draw_bx),
        .i_draw_by    (draw_by),
        .i_erase_req  (erase_req),
        .i_erase_bx   (erase_bx),
        .i_erase_by   (erase_by),
        .i_given_mask (given_mask),
        .o_cls_start  (cls_start),
        .o_cls_track  (cls_track),
        .i_cls_done   (cls_done),
        .i_cls_digit  (cls_digit),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_busy       (busy),
        .o_err        (err),
        .o_err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int wr_seen = 0;
    int cs_seen = 0;
    int w0;
    int c0;

    logic [TW-1:0] ta;
    logic [TW-1:0] tb;
    logic [TW-1:0] tc;
    logic [TW-1:0] td;

    // Pulse counters sampled mid-cycle, for "never happened" checks over a window.
    always @(negedge clk) begin
        if (wr_en)     wr_seen <= wr_seen + 1;
        if (cls_start) cs_seen <= cs_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_draw(input logic [3:0] x, input logic [3:0] y, input logic [TW-1:0] t);
        draw_valid = 1'b1;
        draw_bx    = x;
        draw_by    = y;
        draw_track = t;
    endtask

    task automatic drive_erase(input logic [3:0] x, input logic [3:0] y);
        erase_req = 1'b1;
        erase_bx  = x;
        erase_by  = y;
    endtask

    task automatic clear_req();
        draw_valid = 1'b0;
        erase_req  = 1'b0;
        cls_done   = 1'b0;
        cls_digit  = 4'd0;
    endtask

    initial begin
        ta = {169{16'hA5C3}};
        tb = {169{16'h1234}};
        tc = {169{16'h0F0F}};
        td = {169{16'hBEEF}};
        rst        = 1'b1;
        draw_valid = 1'b0;
        draw_track = '0;
        draw_bx    = 4'd0;
        draw_by    = 4'd0;
        erase_req  = 1'b0;
        erase_bx   = 4'd0;
        erase_by   = 4'd0;
        given_mask = 81'd1;
        cls_done   = 1'b0;
        cls_digit  = 4'd0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_err", err, 0);
        check("rst_cls_start", cls_start, 0);
        check("rst_outs", {wr_addr, wr_data, err_code}, 0);
        rst = 1'b0;
        tick();

        // Draw at (2,3), digit 7 returned a few cycles after cls_start.
        w0 = wr_seen; c0 = cs_seen;
        drive_draw(4'd2, 4'd3, ta);
        tick();
        clear_req();
        check("t1_cls_start", cls_start, 1);
        check("t1_track", 32'(cls_track === ta), 1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_cls_start_pulse", cls_start, 0);
        repeat (4) tick();
        cls_done = 1'b1; cls_digit = 4'd7;
        tick();
        clear_req();
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_addr", wr_addr, 29);
        check("t1_wr_data", wr_data, 7);
        check("t1_err", err, 0);
        tick();
        check("t1_wr_pulse", wr_en, 0);
        check("t1_idle", busy, 0);
        tick();
        check("t1_one_write", wr_seen - w0, 1);
        check("t1_one_start", cs_seen - c0, 1);

        // Draw on the given cell (0,0) and on column 9: both rejected with code 1.
        w0 = wr_seen; c0 = cs_seen;
        drive_draw(4'd0, 4'd0, tb);
        tick();
        clear_req();
        check("t2_err", err, 1);
        check("t2_code", err_code, 1);
        check("t2_busy", busy, 0);
        tick();
        check("t2_err_pulse", err, 0);
        drive_draw(4'd9, 4'd1, tb);
        tick();
        clear_req();
        check("t2_col9_err", {err, err_code}, 3'b101);
        tick();
        tick();
        check("t2_no_activity", (wr_seen - w0) + (cs_seen - c0), 0);

        // Timeout: TIMEOUT=20, no done. Late done with digit 5 must not write.
        w0 = wr_seen;
        drive_draw(4'd4, 4'd4, tc);
        tick();
        clear_req();
        check("t3_cls_start", cls_start, 1);
        repeat (21) tick();
        check("t3_no_early_timeout", err, 0);
        check("t3_busy_waiting", busy, 1);
        tick();
        check("t3_err", err, 1);
        check("t3_code", err_code, 2);
        check("t3_idle", busy, 0);
        tick();
        cls_done = 1'b1; cls_digit = 4'd5;
        tick();
        clear_req();
        tick();
        tick();
        check("t3_no_write", wr_seen - w0, 0);

        // Erase (5,1) and draw (6,2) together in IDLE: erase first, then draw classified.
        drive_erase(4'd5, 4'd1);
        drive_draw(4'd6, 4'd2, td);
        tick();
        clear_req();
        check("t4_erase_wr", wr_en, 1);
        check("t4_erase_addr", wr_addr, 14);
        check("t4_erase_data", wr_data, 0);
        check("t4_no_start_yet", cls_start, 0);
        tick();
        check("t4_slot_busy", {wr_en, busy}, 2'b01);
        tick();
        check("t4_cls_start", cls_start, 1);
        check("t4_track", 32'(cls_track === td), 1);
        tick();
        cls_done = 1'b1; cls_digit = 4'd3;
        tick();
        clear_req();
        check("t4_draw_wr", {wr_en, wr_addr, wr_data}, {1'b1, 7'd24, 4'd3});
        tick();
        tick();

        // Two draws during WAIT: first pends, second overflows; pending one runs next.
        drive_draw(4'd1, 4'd1, ta);
        tick();
        clear_req();
        tick();
        drive_draw(4'd2, 4'd2, tb);
        tick();
        clear_req();
        check("t5_pend_no_err", err, 0);
        drive_draw(4'd3, 4'd3, tc);
        tick();
        clear_req();
        check("t5_overflow", {err, err_code}, 3'b111);
        tick();
        cls_done = 1'b1; cls_digit = 4'd9;
        tick();
        clear_req();
        check("t5_first_wr", {wr_en, wr_addr, wr_data}, {1'b1, 7'd10, 4'd9});
        tick();
        tick();
        check("t5_pending_start", cls_start, 1);
        check("t5_pending_track", 32'(cls_track === tb), 1);
        tick();
        cls_done = 1'b1; cls_digit = 4'd0;
        tick();
        clear_req();
        check("t5_reject", {wr_en, err, err_code}, 4'b0110);
        tick();
        tick();
        check("t5_drained", busy, 0);

        // Reset in WAIT with a pending draw; stale done afterwards must not write.
        drive_draw(4'd7, 4'd7, ta);
        tick();
        clear_req();
        tick();
        drive_draw(4'd8, 4'd0, tb);
        tick();
        clear_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy_after_rst", busy, 0);
        check("t6_outs_after_rst", {wr_en, cls_start, err}, 0);
        w0 = wr_seen; c0 = cs_seen;
        cls_done = 1'b1; cls_digit = 4'd4;
        tick();
        clear_req();
        repeat (3) tick();
        check("t6_no_stale", (wr_seen - w0) + (cs_seen - c0), 0);

        // Erase corner (8,8) -> addr 80; erase on given cell rejected.
        drive_erase(4'd8, 4'd8);
        tick();
        clear_req();
        check("t7_corner_erase", {wr_en, wr_addr, wr_data}, {1'b1, 7'd80, 4'd0});
        tick();
        check("t7_idle", busy, 0);
        drive_erase(4'd0, 4'd0);
        tick();
        clear_req();
        check("t7_given_erase", {wr_en, err, err_code}, 4'b0101);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
